// File: rtl/gc_dram_pkg.sv
// Shared types and constants for the GC-DRAM host-side initiator.
package gc_dram_pkg;

    localparam int unsigned BANK_W   = 3;
    localparam int unsigned ROW_W    = 7;
    localparam int unsigned ADDR_W   = BANK_W + ROW_W;
    localparam int unsigned DATA_W   = 64;
    // Tag width carried through the request FIFO; the top checks its TAG_W against this.
    localparam int unsigned GC_TAG_W = 4;

    typedef struct packed {
        logic                we;
        logic [ADDR_W-1:0]   addr;
        logic [DATA_W-1:0]   wdata;
        logic [GC_TAG_W-1:0] tag;
    } gc_req_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RETRY   = 2'd2
    } gc_host_state_t;

endpackage

// File: rtl/gc_req_fifo.sv
// Synchronous request FIFO of gc_req_t. The ready flag is registered and is
// low while in reset; a push is only taken when ready is already high, so a
// full FIFO never accepts a push in the same cycle that it pops.
module gc_req_fifo
    import gc_dram_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  gc_req_t push_data,
    input  logic    pop,
    output gc_req_t head,
    output logic    empty,
    output logic    ready
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    gc_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ready;
    assign do_pop  = pop & ~empty;
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Occupancy next state; push+pop together leaves the count unchanged.
    always_comb begin
        count_next = count;
        case ({do_push, do_pop})
            2'b10:   count_next = count + CNT_W'(1);
            2'b01:   count_next = count - CNT_W'(1);
            default: count_next = count;
        endcase
    end

    // Pointers, count and the registered not-full flag.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            ready  <= 1'b0;
        end else begin
            // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_next;
            ready <= (count_next != FULL_CNT);
        end
    end

    // Storage; contents are don't-care while the FIFO is empty.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/gc_dram_host_master.sv
// Host-side initiator for the GC-DRAM controller. Client requests are queued
// in gc_req_fifo and issued only while the controller is not refreshing. Read
// data is captured the cycle after issue; a read whose return cycle hits a
// refresh is re-issued from the retry register, blocking younger requests.
// Optional statistics counters are enabled by defining GC_HOST_STATS_EN.
module gc_dram_host_master
    import gc_dram_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned TAG_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [TAG_W-1:0]  req_tag,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [TAG_W-1:0]  rsp_tag,
    input  logic              ctl_busy,
    output logic              ctl_we,
    output logic              ctl_re,
    output logic [ADDR_W-1:0] ctl_waddr,
    output logic [ADDR_W-1:0] ctl_raddr,
    output logic [DATA_W-1:0] ctl_wdata,
    input  logic [DATA_W-1:0] ctl_rd
`ifdef GC_HOST_STATS_EN
    ,
    output logic [31:0]       stat_stall,
    output logic [15:0]       stat_retry
`endif
);

    if (TAG_W != GC_TAG_W) begin : g_bad_tag_w
        $error("gc_dram_host_master: TAG_W must equal gc_dram_pkg::GC_TAG_W");
    end

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("gc_dram_host_master: DEPTH must be a power of two and at least 2");
    end

    gc_host_state_t    state;
    gc_req_t           push_req;
    gc_req_t           head;
    logic              fifo_empty;
    logic              fifo_ready;
    logic              issue_head;
    logic              issue_retry;
    logic [ADDR_W-1:0] retry_addr;
    logic [TAG_W-1:0]  retry_tag;

    assign push_req.we    = req_we;
    assign push_req.addr  = req_addr;
    assign push_req.wdata = req_wdata;
    assign push_req.tag   = req_tag;
    assign req_ready      = fifo_ready;

    gc_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (issue_head),
        .head      (head),
        .empty     (fifo_empty),
        .ready     (fifo_ready)
    );

    // Issue decode: head only from IDLE, retry only from RETRY, never during refresh or reset.
    always_comb begin
        issue_head  = rst & (state == IDLE) & ~fifo_empty & ~ctl_busy;
        issue_retry = rst & (state == RETRY) & ~ctl_busy;
        ctl_we      = issue_head & head.we;
        ctl_re      = (issue_head & ~head.we) | issue_retry;
        ctl_waddr   = '0;
        ctl_wdata   = '0;
        ctl_raddr   = '0;
        if (ctl_we) begin
            ctl_waddr = head.addr;
            ctl_wdata = head.wdata;
        end
        if (issue_retry) begin
            ctl_raddr = retry_addr;
        end else if (ctl_re) begin
            ctl_raddr = head.addr;
        end
    end

    // Read-tracking FSM with registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            retry_addr <= '0;
            retry_tag  <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            rsp_tag    <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (issue_head && !head.we) begin
                        retry_addr <= head.addr;
                        retry_tag  <= head.tag;
                        state      <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    // Controller holds stale rd during refresh, so a busy return cycle is lost.
                    if (!ctl_busy) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= ctl_rd;
                        rsp_tag   <= retry_tag;
                        state     <= IDLE;
                    end else begin
                        state <= RETRY;
                    end
                end
                RETRY: begin
                    if (!ctl_busy) begin
                        state <= RD_WAIT;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef GC_HOST_STATS_EN
    // Saturating stall and retry counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            stat_stall <= '0;
            stat_retry <= '0;
        end else begin
            if (!fifo_empty && ctl_busy && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
            if (issue_retry && stat_retry != '1) begin
                stat_retry <= stat_retry + 16'd1;
            end
        end
    end
`else
    // Statistics disabled: no counters are built.
`endif

endmodule

// File: tb/tb_gc_dram_host_master.sv
// Self-checking bench for gc_dram_host_master: a table of requests with
// expected read data, plus directed sequences for refresh stalls, read-return
// collisions, ordering, mid-read reset and full-FIFO push/pop.
module tb_gc_dram_host_master;
    import gc_dram_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [9:0]  req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic [3:0]  req_tag = '0;
    logic        rsp_valid;
    logic [63:0] rsp_data;
    logic [3:0]  rsp_tag;
    logic        ctl_busy = 1'b0;
    logic        ctl_we;
    logic        ctl_re;
    logic [9:0]  ctl_waddr;
    logic [9:0]  ctl_raddr;
    logic [63:0] ctl_wdata;
    logic [63:0] ctl_rd = '0;
`ifdef GC_HOST_STATS_EN
    logic [31:0] stat_stall;
    logic [15:0] stat_retry;
`endif

    gc_dram_host_master #(
        .DEPTH (4),
        .TAG_W (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_tag   (req_tag),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_tag   (rsp_tag),
        .ctl_busy  (ctl_busy),
        .ctl_we    (ctl_we),
        .ctl_re    (ctl_re),
        .ctl_waddr (ctl_waddr),
        .ctl_raddr (ctl_raddr),
        .ctl_wdata (ctl_wdata),
        .ctl_rd    (ctl_rd)
`ifdef GC_HOST_STATS_EN
        ,
        .stat_stall (stat_stall),
        .stat_retry (stat_retry)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Controller model: memory with read data valid the cycle after ctl_re.
    logic [63:0] cmem [0:1023];
    always @(posedge clk) begin
        if (ctl_we) cmem[ctl_waddr] <= ctl_wdata;
        if (ctl_re) ctl_rd <= cmem[ctl_raddr];
    end

    // Monitor: records issue events and responses at the falling edge.
    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          cyc;
    } obs_t;
    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
    } exp_t;

    obs_t        obs_q[$];
    exp_t        sb_q[$];
    obs_t        mon_o;
    int          we_cnt = 0, re_cnt = 0, rsp_cnt = 0, busy_viol = 0, bus_viol = 0;
    int          last_we_cyc = 0, last_re_cyc = 0;
    logic [9:0]  last_waddr = '0, last_raddr = '0;
    logic [63:0] last_wdata = '0;

    always @(negedge clk) begin
        if (rst) begin
            if (ctl_we) begin
                we_cnt++;
                last_we_cyc = cyc;
                last_waddr  = ctl_waddr;
                last_wdata  = ctl_wdata;
            end
            if (ctl_re) begin
                re_cnt++;
                last_re_cyc = cyc;
                last_raddr  = ctl_raddr;
            end
            if (ctl_busy && (ctl_we || ctl_re)) busy_viol++;
            if ((!ctl_we && (ctl_waddr != '0 || ctl_wdata != '0)) ||
                (!ctl_re && ctl_raddr != '0)) bus_viol++;
            if (rsp_valid) begin
                rsp_cnt++;
                mon_o.tag  = rsp_tag;
                mon_o.data = rsp_data;
                mon_o.cyc  = cyc;
                obs_q.push_back(mon_o);
            end
        end
    end

    int tests = 0;
    int fails = 0;
    int rsp_cyc_tag [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request starting at posedge+1; returns at posedge+1 after acceptance.
    task automatic push_req(input logic we, input logic [9:0] addr, input logic [63:0] data,
                            input logic [3:0] tag, input logic [63:0] exp);
        int   n = 0;
        exp_t e;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = data;
        req_tag   = tag;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("push accepted", {63'd0, req_ready}, 64'd1);
        if (req_ready && !we) begin
            e.tag  = tag;
            e.data = exp;
            sb_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    // Wait for all expected responses, then compare them in order.
    task automatic drain(input string name);
        int   n = 0;
        exp_t e;
        obs_t o;
        while (obs_q.size() < sb_q.size() && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (4) @(negedge clk);
        check({name, " rsp count"}, 64'(obs_q.size()), 64'(sb_q.size()));
        while (sb_q.size() > 0 && obs_q.size() > 0) begin
            e = sb_q.pop_front();
            o = obs_q.pop_front();
            check({name, " rsp tag"}, 64'(o.tag), 64'(e.tag));
            check({name, " rsp data"}, o.data, e.data);
            rsp_cyc_tag[o.tag] = o.cyc;
        end
        sb_q.delete();
        obs_q.delete();
        @(posedge clk);
        #1;
    endtask

    // Raise ctl_busy on the return cycle of the first read to addr, for nbusy cycles.
    task automatic collide(input logic [9:0] addr, input int nbusy, output int fall);
        int n = 0;
        @(negedge clk);
        while (!(ctl_re && ctl_raddr == addr) && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("collision target issued", {63'd0, ctl_re}, 64'd1);
        @(posedge clk);
        #1;
        ctl_busy = 1'b1;
        repeat (nbusy) @(posedge clk);
        #1;
        ctl_busy = 1'b0;
        fall = cyc;
    endtask

    typedef struct {
        logic        we;
        logic [9:0]  addr;
        logic [63:0] wdata;
        logic [3:0]  tag;
        logic [63:0] exp;
    } vec_t;

    function automatic vec_t mk(input logic we, input logic [9:0] addr, input logic [63:0] wdata,
                                input logic [3:0] tag, input logic [63:0] exp);
        vec_t v;
        v.we    = we;
        v.addr  = addr;
        v.wdata = wdata;
        v.tag   = tag;
        v.exp   = exp;
        return v;
    endfunction

    localparam int NV = 11;
    vec_t vecs [NV];

    initial begin
        int w0, r0, rc0, rsp0, fall, y;
        vecs[0]  = mk(1'b1, 10'h000, 64'h0000_0000_0000_0001, 4'd0, 64'd0);
        vecs[1]  = mk(1'b1, 10'h3FF, 64'hFFFF_FFFF_FFFF_FFFE, 4'd1, 64'd0);
        vecs[2]  = mk(1'b1, 10'h380, 64'h1234_5678_9ABC_DEF0, 4'd2, 64'd0);
        vecs[3]  = mk(1'b1, 10'h07F, 64'h0F0F_0F0F_F0F0_F0F0, 4'd3, 64'd0);
        vecs[4]  = mk(1'b0, 10'h000, 64'd0, 4'd4, 64'h0000_0000_0000_0001);
        vecs[5]  = mk(1'b0, 10'h3FF, 64'd0, 4'd5, 64'hFFFF_FFFF_FFFF_FFFE);
        vecs[6]  = mk(1'b0, 10'h380, 64'd0, 4'd6, 64'h1234_5678_9ABC_DEF0);
        vecs[7]  = mk(1'b0, 10'h07F, 64'd0, 4'd7, 64'h0F0F_0F0F_F0F0_F0F0);
        vecs[8]  = mk(1'b1, 10'h000, 64'hCAFE_F00D_0000_0008, 4'd8, 64'd0);
        vecs[9]  = mk(1'b0, 10'h000, 64'd0, 4'd9, 64'hCAFE_F00D_0000_0008);
        vecs[10] = mk(1'b0, 10'h3FF, 64'd0, 4'd15, 64'hFFFF_FFFF_FFFF_FFFE);

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset req_ready", {63'd0, req_ready}, 64'd0);
        check("reset rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("reset rsp_data", rsp_data, 64'd0);
        check("reset rsp_tag", 64'(rsp_tag), 64'd0);
        check("reset ctl_we/re", {62'd0, ctl_we, ctl_re}, 64'd0);
        check("reset ctl buses", {ctl_waddr, ctl_raddr, ctl_wdata[43:0]} | 64'(ctl_wdata[63:44]),
              64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready after reset", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;

        // Table of requests
        for (int i = 0; i < NV; i++) begin
            push_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].tag, vecs[i].exp);
        end
        drain("table");

        // Write then read, no refresh: we at t, re at t+1, rsp at t+3
        push_req(1'b1, 10'h085, 64'hDEADBEEF_01234567, 4'd1, 64'd0);
        push_req(1'b0, 10'h085, 64'd0, 4'd2, 64'hDEADBEEF_01234567);
        drain("wr-rd");
        check("wr-rd waddr", 64'(last_waddr), 64'h085);
        check("wr-rd wdata", last_wdata, 64'hDEADBEEF_01234567);
        check("wr-rd raddr", 64'(last_raddr), 64'h085);
        check("wr-rd re cycle", 64'(last_re_cyc), 64'(last_we_cyc + 1));
        check("wr-rd rsp cycle", 64'(rsp_cyc_tag[2]), 64'(last_we_cyc + 3));

        // Busy stall: 4 writes queued during 10 busy cycles
        ctl_busy = 1'b1;
        w0 = we_cnt;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 10'h100 + 10'(i), 64'h1111_0000_0000_0000 + 64'(i), 4'(i), 64'd0);
        end
        @(negedge clk);
        check("stall full ready", {63'd0, req_ready}, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        check("stall no write", 64'(we_cnt - w0), 64'd0);
        ctl_busy = 1'b0;
        fall = cyc;
        repeat (6) @(posedge clk);
        #1;
        check("stall write count", 64'(we_cnt - w0), 64'd4);
        check("stall writes back-to-back", 64'(last_we_cyc), 64'(fall + 3));
        check("stall last waddr", 64'(last_waddr), 64'h103);
        check("stall ready again", {63'd0, req_ready}, 64'd1);
`ifdef GC_HOST_STATS_EN
        check("stat_stall counted", {63'd0, stat_stall != 32'd0}, 64'd1);
`endif
        push_req(1'b0, 10'h102, 64'd0, 4'd4, 64'h1111_0000_0000_0002);
        drain("stall readback");

        // Read-return collision
        r0 = re_cnt;
        rsp0 = rsp_cnt;
        fork
            push_req(1'b0, 10'h3FF, 64'd0, 4'd7, 64'hFFFF_FFFF_FFFF_FFFE);
            collide(10'h3FF, 3, fall);
        join
        @(negedge clk);
        check("collision no early rsp", 64'(rsp_cnt - rsp0), 64'd0);
        check("collision re-issue re", {63'd0, ctl_re}, 64'd1);
        check("collision re-issue raddr", 64'(ctl_raddr), 64'h3FF);
        @(posedge clk);
        #1;
        drain("collision");
        check("collision single rsp", 64'(rsp_cnt - rsp0), 64'd1);
        check("collision read issues", 64'(re_cnt - r0), 64'd2);
`ifdef GC_HOST_STATS_EN
        check("stat_retry after collision", 64'(stat_retry), 64'd1);
`endif

        // Ordering: B collides, younger write must wait for B
        fork
            begin
                push_req(1'b0, 10'h085, 64'd0, 4'd1, 64'hDEADBEEF_01234567);
                push_req(1'b0, 10'h3FF, 64'd0, 4'd2, 64'hFFFF_FFFF_FFFF_FFFE);
                push_req(1'b1, 10'h3FF, 64'h5555_AAAA_5555_AAAA, 4'd5, 64'd0);
                push_req(1'b0, 10'h3FF, 64'd0, 4'd3, 64'h5555_AAAA_5555_AAAA);
            end
            collide(10'h3FF, 2, fall);
        join
        drain("ordering");
        check("ordering write after B", {63'd0, last_we_cyc >= rsp_cyc_tag[2]}, 64'd1);
        check("ordering A before B", {63'd0, rsp_cyc_tag[1] < rsp_cyc_tag[2]}, 64'd1);
`ifdef GC_HOST_STATS_EN
        check("stat_retry after ordering", 64'(stat_retry), 64'd2);
`endif

        // Full FIFO with a pop: no bypass, push accepted next cycle
        ctl_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(1'b1, 10'h200 + 10'(i), 64'h2222_0000_0000_0000 + 64'(i), 4'(i), 64'd0);
        end
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_addr  = 10'h204;
        req_wdata = 64'h2222_0000_0000_0004;
        req_tag   = 4'd4;
        @(negedge clk);
        check("full ready low", {63'd0, req_ready}, 64'd0);
        w0 = we_cnt;
        @(posedge clk);
        #1;
        ctl_busy = 1'b0;
        y = cyc;
        @(negedge clk);
        check("full+pop ready", {63'd0, req_ready}, 64'd0);
        check("full+pop issue", {63'd0, ctl_we}, 64'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ready after pop", {63'd0, req_ready}, 64'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        check("full+pop write count", 64'(we_cnt - w0), 64'd5);
        check("full+pop last write cycle", 64'(last_we_cyc), 64'(y + 4));
        push_req(1'b0, 10'h204, 64'd0, 4'd6, 64'h2222_0000_0000_0004);
        push_req(1'b0, 10'h200, 64'd0, 4'd7, 64'h2222_0000_0000_0000);
        drain("full+pop readback");

        // Reset in RD_WAIT with 3 entries queued
        ctl_busy = 1'b1;
        push_req(1'b0, 10'h000, 64'd0, 4'd1, 64'hCAFE_F00D_0000_0008);
        push_req(1'b0, 10'h380, 64'd0, 4'd2, 64'h1234_5678_9ABC_DEF0);
        push_req(1'b0, 10'h07F, 64'd0, 4'd3, 64'h0F0F_0F0F_F0F0_F0F0);
        push_req(1'b0, 10'h085, 64'd0, 4'd4, 64'hDEADBEEF_01234567);
        ctl_busy = 1'b0;
        rc0 = re_cnt;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb_q.delete();
        rsp0 = rsp_cnt;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid-reset first read issued", 64'(re_cnt - rc0), 64'd1);
        check("mid-reset ready low", {63'd0, req_ready}, 64'd0);
        check("mid-reset rsp_data", rsp_data, 64'd0);
`ifdef GC_HOST_STATS_EN
        check("mid-reset stat_stall", 64'(stat_stall), 64'd0);
        check("mid-reset stat_retry", 64'(stat_retry), 64'd0);
`endif
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post-reset ready", {63'd0, req_ready}, 64'd1);
        check("post-reset fifo empty", {62'd0, ctl_we, ctl_re}, 64'd0);
        repeat (10) @(posedge clk);
        #1;
        check("mid-reset no rsp", 64'(rsp_cnt - rsp0), 64'd0);
        push_req(1'b0, 10'h3FF, 64'd0, 4'd9, 64'h5555_AAAA_5555_AAAA);
        drain("post-reset read");

        check("no issue while busy", 64'(busy_viol), 64'd0);
        check("idle buses zero", 64'(bus_viol), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
